// File: rtl/rgmii_rx_decode_pkg.sv
// Shared ethernet definitions for the RGMII receive decoder: speed
// encodings, in-band status bit positions and the nibble FSM states.
package rgmii_rx_decode_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // In-band status carried on RXD during inter-frame gaps
    localparam int INB_LINK_BIT   = 0;
    localparam int INB_SPEED_LSB  = 1;
    localparam int INB_SPEED_MSB  = 2;
    localparam int INB_DUPLEX_BIT = 3;

    // RXD code that marks a false carrier when dv=0 and er=1
    localparam logic [3:0] FALSE_CARRIER_CODE = 4'hE;

    typedef enum logic {
        NIB_LOW  = 1'b0,
        NIB_HIGH = 1'b1
    } nib_state_t;

    // The reserved encoding 2'b11 runs as gigabit
    function automatic logic [1:0] norm_speed(input logic [1:0] spd);
        logic [1:0] res;
        case (spd)
            SPEED_10:  res = SPEED_10;
            SPEED_100: res = SPEED_100;
            default:   res = SPEED_1000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rgmii_rx_decode_nibble_pack.sv
// 10/100 nibble packer: assembles two RXD nibbles (low first) into a byte.
// Byte outputs are combinational; the top registers them, which gives the
// byte strobe on the cycle after the high nibble arrives.
module rgmii_nibble_pack
    import rgmii_rx_decode_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] nib,
    input  logic       dv,
    input  logic       er,
    output logic [7:0] byte_data,
    output logic       byte_dv,
    output logic       byte_er,
    output logic       byte_valid
);

    nib_state_t state_r, state_s;
    logic [3:0] low_r, low_s;
    logic       er_acc_r, er_acc_s;
    logic       phase_r, phase_s;

    // Next-state and byte emission for the LOW/HIGH nibble FSM
    always_comb begin
        state_s    = state_r;
        low_s      = low_r;
        er_acc_s   = er_acc_r;
        phase_s    = phase_r;
        byte_data  = 8'h00;
        byte_dv    = 1'b0;
        byte_er    = 1'b0;
        byte_valid = 1'b0;
        if (!en || clr) begin
            // Gigabit mode or a speed change: drop any partial nibble
            state_s  = NIB_LOW;
            low_s    = 4'h0;
            er_acc_s = 1'b0;
            phase_s  = 1'b0;
        end else begin
            case (state_r)
                NIB_LOW: begin
                    if (dv) begin
                        low_s    = nib;
                        er_acc_s = er;
                        phase_s  = 1'b0;
                        state_s  = NIB_HIGH;
                    end else if (!phase_r) begin
                        // Idle: strobe every second cycle to keep the rate fixed
                        er_acc_s = er;
                        phase_s  = 1'b1;
                    end else begin
                        byte_valid = 1'b1;
                        byte_er    = er_acc_r | er;
                        phase_s    = 1'b0;
                    end
                end
                NIB_HIGH: begin
                    byte_valid = 1'b1;
                    byte_dv    = 1'b1;
                    phase_s    = 1'b0;
                    state_s    = NIB_LOW;
                    if (dv) begin
                        byte_data = {nib, low_r};
                        byte_er   = er_acc_r | er;
                    end else begin
                        // Frame ended on an odd nibble: flag the truncated byte
                        byte_data = {4'h0, low_r};
                        byte_er   = 1'b1;
                    end
                end
                default: begin
                    state_s = NIB_LOW;
                end
            endcase
        end
    end

    // FSM and nibble holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= NIB_LOW;
            low_r    <= 4'h0;
            er_acc_r <= 1'b0;
            phase_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            low_r    <= low_s;
            er_acc_r <= er_acc_s;
            phase_r  <= phase_s;
        end
    end

endmodule

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns DDR-captured RXD/RX_CTL into GMII bytes,
// tracks in-band link status and flags false carrier events.
module rgmii_rx_decode
    import rgmii_rx_decode_pkg::*;
#(
    parameter bit INBAND_STATUS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [3:0] rx_d_q1,
    input  logic [3:0] rx_d_q2,
    input  logic       rx_ctl_q1,
    input  logic       rx_ctl_q2,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       false_carrier
);

    logic       dv_s;
    logic       er_s;
    logic [1:0] speed_req_s;
    logic [1:0] speed_eff_s;
    logic [1:0] speed_r;
    logic       speed_chg_s;
    logic       gig_s;
    logic       fc_det_s;
    logic       status_upd_s;
    logic [7:0] pk_data_s;
    logic       pk_dv_s;
    logic       pk_er_s;
    logic       pk_valid_s;

    // Per-cycle control decode, speed freeze during frames, event detection
    always_comb begin
        dv_s         = rx_ctl_q1;
        er_s         = rx_ctl_q1 ^ rx_ctl_q2;
        speed_req_s  = norm_speed(speed);
        speed_eff_s  = dv_s ? speed_r : speed_req_s;
        speed_chg_s  = !dv_s && (speed_req_s != speed_r);
        gig_s        = (speed_eff_s == SPEED_1000);
        // Gigabit needs the code on both edges; 10/100 only looks at q1
        fc_det_s     = !dv_s && er_s && (rx_d_q1 == FALSE_CARRIER_CODE)
                       && (!gig_s || (rx_d_q2 == FALSE_CARRIER_CODE));
        status_upd_s = INBAND_STATUS_EN && !dv_s && !er_s;
    end

    rgmii_nibble_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .en         (!gig_s),
        .clr        (speed_chg_s),
        .nib        (rx_d_q1),
        .dv         (dv_s),
        .er         (er_s),
        .byte_data  (pk_data_s),
        .byte_dv    (pk_dv_s),
        .byte_er    (pk_er_s),
        .byte_valid (pk_valid_s)
    );

    // Effective speed; only moves while dv is low
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_r <= speed_req_s;
        end else begin
            speed_r <= speed_eff_s;
        end
    end

    // GMII byte output register: direct DDR byte at 1000M, packed byte at 10/100
    always_ff @(posedge clk) begin
        if (rst) begin
            gmii_rxd      <= 8'h00;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_rx_valid <= 1'b0;
        end else if (gig_s) begin
            gmii_rxd      <= {rx_d_q2, rx_d_q1};
            gmii_rx_dv    <= dv_s;
            gmii_rx_er    <= er_s;
            gmii_rx_valid <= 1'b1;
        end else begin
            gmii_rxd      <= pk_data_s;
            gmii_rx_dv    <= pk_dv_s;
            gmii_rx_er    <= pk_er_s;
            gmii_rx_valid <= pk_valid_s;
        end
    end

    // In-band status: sampled only on clean idle cycles, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            link_up     <= 1'b0;
            link_speed  <= 2'b00;
            full_duplex <= 1'b0;
        end else if (status_upd_s) begin
            link_up     <= rx_d_q1[INB_LINK_BIT];
            link_speed  <= rx_d_q1[INB_SPEED_MSB:INB_SPEED_LSB];
            full_duplex <= rx_d_q1[INB_DUPLEX_BIT];
        end else begin
            link_up     <= link_up;
            link_speed  <= link_speed;
            full_duplex <= full_duplex;
        end
    end

    // False carrier pulse, one cycle after detection
    always_ff @(posedge clk) begin
        if (rst) begin
            false_carrier <= 1'b0;
        end else begin
            false_carrier <= fc_det_s;
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed, table-driven bench for rgmii_rx_decode.
module tb_rgmii_rx_decode;

    logic       clk;
    logic       rst;
    logic [1:0] speed;
    logic [3:0] rx_d_q1;
    logic [3:0] rx_d_q2;
    logic       rx_ctl_q1;
    logic       rx_ctl_q2;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_rx_valid;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;
    logic       false_carrier;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] spd;
        logic [3:0] q1;
        logic [3:0] q2;
        logic       c1;
        logic       c2;
        logic       valid;
        logic       dv;
        logic       er;
        logic       chkd;
        logic [7:0] rxd;
        logic       link;
        logic [1:0] lspd;
        logic       fd;
        logic       fc;
    } vec_t;

    localparam int NVEC = 50;
    vec_t tbl [0:NVEC-1];

    rgmii_rx_decode dut (
        .clk           (clk),
        .rst           (rst),
        .speed         (speed),
        .rx_d_q1       (rx_d_q1),
        .rx_d_q2       (rx_d_q2),
        .rx_ctl_q1     (rx_ctl_q1),
        .rx_ctl_q2     (rx_ctl_q2),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .gmii_rx_valid (gmii_rx_valid),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .full_duplex   (full_duplex),
        .false_carrier (false_carrier)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [1:0] s,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic c1, input logic c2,
                                input logic vl, input logic d, input logic e,
                                input logic cd, input logic [7:0] x,
                                input logic lk, input logic [1:0] ls,
                                input logic f, input logic fc);
        vec_t t;
        t.rst = r;  t.spd = s;   t.q1 = a;    t.q2 = b;  t.c1 = c1; t.c2 = c2;
        t.valid = vl; t.dv = d;  t.er = e;    t.chkd = cd; t.rxd = x;
        t.link = lk; t.lspd = ls; t.fd = f;   t.fc = fc;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] s, input logic [3:0] a,
                         input logic [3:0] b, input logic c1, input logic c2);
        rst       = r;
        speed     = s;
        rx_d_q1   = a;
        rx_d_q2   = b;
        rx_ctl_q1 = c1;
        rx_ctl_q2 = c2;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] T = 2'b00;

    initial begin
        rst = 1'b1; speed = G; rx_d_q1 = 4'h0; rx_d_q2 = 4'h0;
        rx_ctl_q1 = 1'b0; rx_ctl_q2 = 1'b0;

        //             rst spd q1    q2    c1    c2    val   dv    er    chkd  rxd    lnk   lspd   fd    fc
        tbl[0]  = mk(1'b1, G, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, G, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, G, 4'hD, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, G, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, G, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, G, 4'h5, 4'hD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD5, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, G, 4'hD, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, G, 4'hE, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 2'b10, 1'b1, 1'b1);
        tbl[8]  = mk(1'b0, G, 4'hD, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, G, 4'h3, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h73, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, H, 4'h5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, H, 4'h5, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, H, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, H, 4'hD, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD5, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[19] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[20] = mk(1'b0, H, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[21] = mk(1'b0, H, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h21, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[22] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[23] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[24] = mk(1'b0, T, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[25] = mk(1'b0, T, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[26] = mk(1'b0, T, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[27] = mk(1'b0, T, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[28] = mk(1'b0, T, 4'hB, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hBA, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[29] = mk(1'b0, T, 4'hC, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[30] = mk(1'b0, T, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[31] = mk(1'b0, T, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[32] = mk(1'b0, T, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[33] = mk(1'b0, T, 4'h6, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[34] = mk(1'b0, H, 4'h9, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h96, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[35] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[36] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[37] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[38] = mk(1'b0, H, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[39] = mk(1'b0, G, 4'hD, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[40] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[41] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[42] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[43] = mk(1'b0, H, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[44] = mk(1'b1, H, 4'hD, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        tbl[45] = mk(1'b0, H, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        tbl[46] = mk(1'b0, H, 4'h2, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 1'b0, 2'b00, 1'b0, 1'b0);
        tbl[47] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
        tbl[48] = mk(1'b0, H, 4'hE, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1);
        tbl[49] = mk(1'b0, H, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0);

        @(negedge clk);
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].spd, tbl[i].q1, tbl[i].q2, tbl[i].c1, tbl[i].c2);
            chk("valid", i, 8'(gmii_rx_valid), 8'(tbl[i].valid));
            if (tbl[i].valid || tbl[i].chkd) begin
                chk("dv", i, 8'(gmii_rx_dv), 8'(tbl[i].dv));
            end
            if (tbl[i].chkd) begin
                chk("rxd", i, gmii_rxd, tbl[i].rxd);
                chk("er", i, 8'(gmii_rx_er), 8'(tbl[i].er));
            end
            chk("link_up", i, 8'(link_up), 8'(tbl[i].link));
            chk("link_speed", i, 8'(link_speed), 8'(tbl[i].lspd));
            chk("full_duplex", i, 8'(full_duplex), 8'(tbl[i].fd));
            chk("false_carrier", i, 8'(false_carrier), 8'(tbl[i].fc));
        end

        // Back to gigabit: speed can only move while dv is low
        drive(1'b0, G, 4'hD, 4'hD, 1'b0, 1'b0);
        chk("gig_idle_valid", 100, 8'(gmii_rx_valid), 8'h01);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] lo;
            logic [3:0] hi;
            lo = 4'(i);
            hi = 4'(15 - i);
            drive(1'b0, G, lo, hi, 1'b1, 1'b1);
            chk("gig_stream_rxd", 101 + i, gmii_rxd, {hi, lo});
            chk("gig_stream_dv", 101 + i, 8'(gmii_rx_dv), 8'h01);
        end

        // Gigabit false carrier needs 0xE on both edges
        drive(1'b0, G, 4'hE, 4'h0, 1'b0, 1'b1);
        chk("fc_one_edge", 110, 8'(false_carrier), 8'h00);
        chk("fc_one_edge_status", 110, 8'(link_up), 8'h01);
        drive(1'b0, G, 4'hE, 4'hE, 1'b0, 1'b1);
        chk("fc_both_edges", 111, 8'(false_carrier), 8'h01);
        drive(1'b0, G, 4'hD, 4'hD, 1'b0, 1'b0);
        chk("fc_pulse_end", 112, 8'(false_carrier), 8'h00);

        // Speed encoding 2'b11 behaves as gigabit
        drive(1'b0, 2'b11, 4'h4, 4'hA, 1'b1, 1'b1);
        chk("spd11_rxd", 113, gmii_rxd, 8'hA4);
        chk("spd11_valid", 113, 8'(gmii_rx_valid), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
